tm1638_readkeys: RTL

- Read-side counterpart of the TM1638 byte writer. After the controller has sent the read-key command (0x42) with STB low, this block releases DIO and waits the tWAIT gap.
- It then clocks in the 4 key-scan bytes (LSB first), latches the 32-bit raw scan and decodes the 8 front-panel keys.
- Sits beside the byte writer under the TM1638 controller. The controller muxes dev_clk and owns STB and DIO direction.

---
 rtl/tm1638_readkeys_if.sv | 12 +
 rtl/tm1638_readkeys.sv | 63 ++++++
 2 files changed

// File: rtl/tm1638_readkeys_if.sv
// tm1638_readkeys_if: read request, TM1638 CLK/DIO pins and decoded key result.
interface tm1638_readkeys_if;
  logic start;
  logic busy;
  logic dev_din;
  logic dev_clk;
  logic data_valid;
  logic [31:0] raw;
  logic [7:0] keys;
  modport master(output start, dev_din, input busy, dev_clk, data_valid, raw, keys);
  modport slave(input start, dev_din, output busy, dev_clk, data_valid, raw, keys);
endinterface

// File: rtl/tm1638_readkeys.sv
// tm1638_readkeys: after the read-key command, wait tWAIT, clock in 4 scan bytes LSB first and decode 8 keys.
module tm1638_readkeys #(
  parameter int WAIT_CYCLES = 2
) (
  input logic drvclk,
  input logic reset,
  tm1638_readkeys_if.slave bus
);
  localparam int WW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, READ} state_t;
  state_t state;
  logic [WW-1:0] wcnt;
  logic [5:0] bcnt;
  logic [31:0] shift;
  logic [7:0] dec;
  assign bus.busy = state != IDLE;
  // key n sits at bit 0 (n<4) or bit 4 (n>=4) of scan byte n mod 4
  always_comb begin
    dec = '0;
    for (int n = 0; n < 8; n++) dec[n] = shift[8*(n%4) + 4*(n/4)];
  end
  always_ff @(posedge drvclk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt <= '0;
      bcnt <= '0;
      shift <= '0;
      bus.dev_clk <= 1'b1;
      bus.data_valid <= 1'b0;
      bus.raw <= '0;
      bus.keys <= '0;
    end else begin
      bus.data_valid <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= WAIT;
          wcnt <= '0;
        end
        WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WW'(WAIT_CYCLES - 1)) begin
            state <= READ;
            bus.dev_clk <= 1'b0;
            bcnt <= '0;
          end
        end
        READ: if (!bus.dev_clk) begin
          bus.dev_clk <= 1'b1;
          shift[bcnt[4:0]] <= bus.dev_din;
          bcnt <= bcnt + 1'b1;
        end else if (!bcnt[5]) begin
          bus.dev_clk <= 1'b0;
        end else begin
          state <= IDLE;
          bus.raw <= shift;
          bus.keys <= dec;
          bus.data_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
